// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared ARM constants. Holds the CPSR field positions, the
//               processor mode encodings and the barrel-shift types used
//               across the core, plus the instruction fetch configuration.
//               Fetch buffering depth is chosen by the macro FETCH_SKID_EN:
//                 defined   -> 2 entries (pipelined, one insn per cycle)
//                 undefined -> 1 entry  (one request in flight at a time)
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // CPSR flag bit positions
    localparam int c_CPSR_N_BIT = 31;
    localparam int c_CPSR_Z_BIT = 30;
    localparam int c_CPSR_C_BIT = 29;
    localparam int c_CPSR_V_BIT = 28;
    localparam int c_CPSR_T_BIT = 5;

    typedef enum logic [4:0] {
        MODE_USR = 5'h10,
        MODE_FIQ = 5'h11,
        MODE_IRQ = 5'h12,
        MODE_SVC = 5'h13,
        MODE_ABT = 5'h17,
        MODE_UND = 5'h1B,
        MODE_SYS = 5'h1F
    } cpsr_mode_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'd0,
        SHIFT_LSR = 2'd1,
        SHIFT_ASR = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_type_e;

    // Instruction fetch configuration
    localparam logic [31:0] c_RESET_VEC = 32'h0000_0000;

`ifdef FETCH_SKID_EN
    localparam int c_FETCH_DEPTH = 2;
`else
    localparam int c_FETCH_DEPTH = 1;
`endif

    // Counters must hold 0..DEPTH inclusive
    localparam int c_FETCH_CNT_W = $clog2(c_FETCH_DEPTH + 1);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small FIFO holding returned {instruction, address} entries.
//               Push and pop may coincide at any occupancy, including full
//               (the caller never pushes into a full FIFO without popping).
//               Flush empties the FIFO and overrides push/pop.
// Ports       : clk, rst (async, active-high), push/wdata, pop/rdata,
//               flush, empty, count (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    if (DEPTH == 1) begin : g_one
        logic [WIDTH-1:0] r_data;
        logic             r_full;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_full <= 1'b0;
            end else if (flush) begin
                r_full <= 1'b0;
            end else if (push) begin
                r_full <= 1'b1;
            end else if (pop) begin
                r_full <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (push && !flush) begin
                r_data <= wdata;
            end
        end

        assign rdata = r_data;
        assign empty = !r_full;
        assign count = CNT_W'(r_full);
    end else begin : g_ring
        localparam int c_PTR_W = $clog2(DEPTH);

        logic [WIDTH-1:0]   r_mem [DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0]   r_count;

        function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
            return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
        endfunction

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (push) begin
                    r_wptr <= f_inc(r_wptr);
                end
                if (pop) begin
                    r_rptr <= f_inc(r_rptr);
                end
                r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
            end
        end

        always_ff @(posedge clk) begin
            if (push && !flush) begin
                r_mem[r_wptr] <= wdata;
            end
        end

        assign rdata = r_mem[r_rptr];
        assign empty = (r_count == '0);
        assign count = r_count;
    end

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch
// Description : Instruction fetch stage. Issues word reads to the I-cache,
//               buffers returned words with their addresses, and presents
//               them to decode through an output register. A redirect (jmp)
//               flushes the buffer and discards responses still in flight.
//               Build macro FETCH_SKID_EN selects a 2-entry budget
//               (pipelined); without it only one request is in flight.
// Ports       : clk, rst           - clock, async active-high reset
//               ic_req/ic_addr     - cache request (ic_ready handshake)
//               ic_rvalid/ic_rdata - in-order cache response
//               jmp/jmppc          - redirect from execute
//               stall              - decode back-pressure
//               bubble/insn/pc     - to decode; pc = fetch address + 8
// Revision    : 1.0 - initial release
// ============================================================================
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = c_RESET_VEC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ready,
    input  logic        ic_rvalid,
    input  logic [31:0] ic_rdata,
    input  logic        jmp,
    input  logic [31:0] jmppc,
    input  logic        stall,
    output logic        bubble,
    output logic [31:0] insn,
    output logic [31:0] pc
);

    localparam int c_DEPTH = c_FETCH_DEPTH;
    localparam int c_CW    = c_FETCH_CNT_W;

    logic [31:0]     r_fpc;
    logic [c_CW-1:0] r_outs;
    logic [c_CW-1:0] r_drop;
    logic            r_bubble;
    logic [31:0]     r_insn;
    logic [31:0]     r_pc;

    logic [c_CW-1:0] w_fifo_count;
    logic            w_fifo_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_entry;
    logic            w_pop;
    logic            w_push;
    logic            w_accept;
    logic [c_CW:0]   w_used;
    logic [31:0]     w_rsp_addr;

    assign w_pop = !jmp && !stall && !w_fifo_empty;

    // Slots in use: in-flight requests plus buffered words. A slot being
    // popped this cycle counts as free so that a 1-cycle cache can sustain
    // one instruction per cycle at the 2-entry depth.
    assign w_used   = {1'b0, r_outs} + {1'b0, w_fifo_count} - (c_CW + 1)'(w_pop);
    assign ic_req   = !rst && !jmp && (w_used < (c_CW + 1)'(c_DEPTH));
    assign ic_addr  = r_fpc;
    assign w_accept = ic_req && ic_ready;

    // Responses return in order and dropped ones are always the oldest, so
    // a kept response (drop == 0) belongs to the oldest in-flight request,
    // which sits outs words behind the fetch pointer.
    assign w_rsp_addr = r_fpc - 32'({r_outs, 2'b00});
    assign w_push     = ic_rvalid && !jmp && (r_drop == '0);
    assign w_entry    = '{word: ic_rdata, addr: w_rsp_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc  <= word_align(RESET_VEC);
            r_outs <= '0;
            r_drop <= '0;
        end else begin
            r_outs <= r_outs + c_CW'(w_accept) - c_CW'(ic_rvalid);
            if (jmp) begin
                r_fpc  <= word_align(jmppc);
                // Everything still in flight is stale; a response arriving
                // now is discarded directly and needs no drop credit.
                r_drop <= r_outs - c_CW'(ic_rvalid && (r_outs != '0));
            end else begin
                if (w_accept) begin
                    r_fpc <= r_fpc + 32'd4;
                end
                if (ic_rvalid && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble <= 1'b1;
            r_insn   <= '0;
            r_pc     <= '0;
        end else if (jmp) begin
            r_bubble <= 1'b1;
        end else if (!stall) begin
            if (!w_fifo_empty) begin
                r_bubble <= 1'b0;
                r_insn   <= w_head.word;
                r_pc     <= w_head.addr + 32'd8;
            end else begin
                r_bubble <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (c_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_entry),
        .pop   (w_pop),
        .flush (jmp),
        .rdata (w_head),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign bubble = r_bubble;
    assign insn   = r_insn;
    assign pc     = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch
// Description : Directed self-checking bench for fetch. A 1-cycle latency
//               cache model returns word E3A00001 + addr/4 for each address.
//               Every instruction handed to decode is checked against the
//               expected sequential / redirected stream. Cycle-exact checks
//               depend on FETCH_SKID_EN, matching the RTL build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic        ic_rvalid;
    logic [31:0] ic_rdata;
    logic        jmp;
    logic [31:0] jmppc;
    logic        stall;
    logic        bubble;
    logic [31:0] insn;
    logic [31:0] pc;

    fetch #(.RESET_VEC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .ic_rvalid (ic_rvalid),
        .ic_rdata  (ic_rdata),
        .jmp       (jmp),
        .jmppc     (jmppc),
        .stall     (stall),
        .bubble    (bubble),
        .insn      (insn),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int          n_total;
    int          n_bad;
    int          n_req_busy;
    logic        rsp_en;
    logic [31:0] exp_pc;
    logic [31:0] pend[$];
    logic [31:0] acc_q[$];
    logic [31:0] deliv_q[$];
    logic        obs_bubble;
    logic        obs_req;
    logic [31:0] obs_pc;
    logic [31:0] obs_insn;
    logic [31:0] obs_addr;
    logic        b_log [8];
    logic [31:0] p_log [8];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hE3A0_0001 + (a >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the cache response, sample outputs, check any
    // instruction decode takes, then update the cache model at the edge.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        if (rsp_en && pend.size() != 0) begin
            ic_rvalid = 1'b1;
            ic_rdata  = word_at(pend[0]);
        end else begin
            ic_rvalid = 1'b0;
            ic_rdata  = 32'h0;
        end
        #1;
        acc        = ic_req && ic_ready;
        a          = ic_addr;
        obs_bubble = bubble;
        obs_req    = ic_req;
        obs_pc     = pc;
        obs_insn   = insn;
        obs_addr   = ic_addr;
        if (ic_req && pend.size() != 0) n_req_busy++;
        if (!rst && !bubble) begin
            check("stream_pc", pc, exp_pc);
            check("stream_insn", insn, word_at(exp_pc - 32'd8));
            if (!stall) begin
                deliv_q.push_back(pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (jmp) exp_pc = jmppc + 32'd8;
        @(posedge clk);
        if (ic_rvalid) void'(pend.pop_front());
        if (acc) begin
            pend.push_back(a);
            acc_q.push_back(a);
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = !obs_bubble;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int base;
        rst = 1'b1; ic_ready = 1'b1; ic_rvalid = 1'b0; ic_rdata = 32'h0;
        jmp = 1'b0; jmppc = 32'h0; stall = 1'b0; rsp_en = 1'b1;
        exp_pc = 32'h8; n_total = 0; n_bad = 0; n_req_busy = 0;

        // Reset state
        @(negedge clk);
        step();
        check("rst_req", 32'(obs_req), 32'd0);
        check("rst_bubble", 32'(obs_bubble), 32'd1);
        check("rst_insn", obs_insn, 32'h0);
        check("rst_pc", obs_pc, 32'h0);
        step();
        rst = 1'b0;

        // Start-up from reset vector
        for (int i = 0; i < 8; i++) begin
            step();
            b_log[i] = obs_bubble;
            p_log[i] = obs_pc;
            if (i == 0) begin
                check("first_req", 32'(obs_req), 32'd1);
                check("first_addr", obs_addr, 32'h0);
            end
        end
        check("s2_bubble", 32'(b_log[2]), 32'd1);
        check("s3_bubble", 32'(b_log[3]), 32'd0);
        check("s3_pc", p_log[3], 32'h8);
`ifdef FETCH_SKID_EN
        check("s4_bubble", 32'(b_log[4]), 32'd0);
        check("s4_pc", p_log[4], 32'hC);
        check("s5_pc", p_log[5], 32'h10);
`else
        check("s4_bubble", 32'(b_log[4]), 32'd1);
        check("s5_bubble", 32'(b_log[5]), 32'd0);
        check("s5_pc", p_log[5], 32'hC);
        check("s6_bubble", 32'(b_log[6]), 32'd1);
`endif
        check("acc0", acc_q[0], 32'h0);
        check("acc1", acc_q[1], 32'h4);
        check("acc2", acc_q[2], 32'h8);

        // Stall with full buffer
        stall = 1'b1;
        step();
        step();
        check("stall_req1", 32'(obs_req), 32'd0);
        step();
        check("stall_req2", 32'(obs_req), 32'd0);
        stall = 1'b0;
        d0 = deliv_q.size();
        repeat (6) step();
        check("stall_resume", (deliv_q.size() - d0 >= 2) ? 32'd1 : 32'd0, 32'd1);

        // Redirect with the request budget fully in flight
        rsp_en = 1'b0;
        repeat (4) step();
`ifdef FETCH_SKID_EN
        check("j37_outs", 32'(pend.size()), 32'd2);
`else
        check("j37_outs", 32'(pend.size()), 32'd1);
`endif
        jmp = 1'b1; jmppc = 32'h100;
        step();
        check("j37_noreq", 32'(obs_req), 32'd0);
        jmp = 1'b0; rsp_en = 1'b1;
        step();
        check("j37_bubble", 32'(obs_bubble), 32'd1);
        wait_valid("j37_timeout");
        check("j37_pc", obs_pc, 32'h108);
        check("j37_insn", obs_insn, 32'hE3A0_0041);

        // Redirect together with stall and a returning response
        repeat (4) step();
        rsp_en = 1'b0;
        repeat (4) step();
        rsp_en = 1'b1; jmp = 1'b1; stall = 1'b1; jmppc = 32'h200;
        step();
        jmp = 1'b0; stall = 1'b0;
        step();
        check("j38_bubble", 32'(obs_bubble), 32'd1);
        wait_valid("j38_timeout");
        check("j38_pc", obs_pc, 32'h208);
        check("j38_insn", obs_insn, 32'hE3A0_0081);

        // Address wrap at the top of memory
        repeat (4) step();
        jmp = 1'b1; jmppc = 32'hFFFF_FFFC;
        step();
        check("wrap_noreq", 32'(obs_req), 32'd0);
        jmp = 1'b0;
        base = acc_q.size();
        d0 = deliv_q.size();
        for (int i = 0; i < 30 && deliv_q.size() < d0 + 2; i++) step();
        check("wrap_count", (deliv_q.size() >= d0 + 2) ? 32'd1 : 32'd0, 32'd1);
        check("wrap_acc0", acc_q[base], 32'hFFFF_FFFC);
        check("wrap_acc1", acc_q[base + 1], 32'h0);
        check("wrap_pc0", deliv_q[d0], 32'h4);
        check("wrap_pc1", deliv_q[d0 + 1], 32'h8);

`ifdef FETCH_SKID_EN
        check("pipelined_req", (n_req_busy != 0) ? 32'd1 : 32'd0, 32'd1);
`else
        check("single_outstanding", 32'(n_req_busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
